// File: rtl/and_or_result_fifo.sv
// and_or_result_fifo: registered result buffer behind and_or.
// Buffers {isAnd, out} pairs over valid/ready, with saturating AND/OR counts and a sticky overflow flag.
`default_nettype none

module and_or_result_fifo #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic                     isAnd,
  input  logic [WIDTH-1:0]         resultIn,
  output logic                     outValid,
  input  logic                     outReady,
  output logic                     outIsAnd,
  output logic [WIDTH-1:0]         outData,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_WIDTH-1:0]     andCount,
  output logic [CNT_WIDTH-1:0]     orCount,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH:0]         mem_q [DEPTH];
  logic [AW:0]            wp_q, wp_d;
  logic [AW:0]            rp_q, rp_d;
  logic [CNT_WIDTH-1:0]   and_cnt_q, and_cnt_d;
  logic [CNT_WIDTH-1:0]   or_cnt_q, or_cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   full, empty, push, pop;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  always_comb begin
    empty = (wp_q == rp_q);
    full  = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
    push  = inValid && !full;
    pop   = !empty && outReady;

    wp_d = push ? wp_q + 1'b1 : wp_q;
    rp_d = pop  ? rp_q + 1'b1 : rp_q;

    and_cnt_d = and_cnt_q;
    or_cnt_d  = or_cnt_q;
    if (push && isAnd && (and_cnt_q != {CNT_WIDTH{1'b1}})) begin
      and_cnt_d = and_cnt_q + 1'b1;
    end
    if (push && !isAnd && (or_cnt_q != {CNT_WIDTH{1'b1}})) begin
      or_cnt_d = or_cnt_q + 1'b1;
    end

    ovf_d = ovf_q || (inValid && full);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q      <= '0;
      rp_q      <= '0;
      and_cnt_q <= '0;
      or_cnt_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      and_cnt_q <= and_cnt_d;
      or_cnt_q  <= or_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage needs no reset: entries are only observable through the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wp_q[AW-1:0]] <= {isAnd, resultIn};
    end
  end

  assign inReady  = !full;
  assign outValid = !empty;
  assign outIsAnd = mem_q[rp_q[AW-1:0]][WIDTH];
  assign outData  = mem_q[rp_q[AW-1:0]][WIDTH-1:0];
  assign level    = wp_q - rp_q;
  assign andCount = and_cnt_q;
  assign orCount  = or_cnt_q;
  assign overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_and_or_result_fifo.sv
// tb_and_or_result_fifo: queue-based reference model checked every cycle, plus directed literal checks.
`default_nettype none

module tb_and_or_result_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic inValid = 1'b0, isAnd = 1'b0, outReady = 1'b0;
  logic [WIDTH-1:0] resultIn = '0;

  logic inReady, outValid, outIsAnd, overflow;
  logic [WIDTH-1:0] outData;
  logic [2:0] level;
  logic [7:0] andCount, orCount;

  logic inReady2, outValid2, outIsAnd2, overflow2;
  logic [WIDTH-1:0] outData2;
  logic [2:0] level2;
  logic [1:0] andCount2, orCount2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  and_or_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady), .isAnd(isAnd),
    .resultIn(resultIn), .outValid(outValid), .outReady(outReady), .outIsAnd(outIsAnd),
    .outData(outData), .level(level), .andCount(andCount), .orCount(orCount),
    .overflow(overflow)
  );

  and_or_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady2), .isAnd(isAnd),
    .resultIn(resultIn), .outValid(outValid2), .outReady(outReady), .outIsAnd(outIsAnd2),
    .outData(outData2), .level(level2), .andCount(andCount2), .orCount(orCount2),
    .overflow(overflow2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {isAnd, data} plus unbounded counts.
  logic [WIDTH:0] mq[$];
  int and_m = 0, or_m = 0;
  bit ovf_m = 0;
  bit m_full, m_empty;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      and_m = 0;
      or_m  = 0;
      ovf_m = 0;
    end else begin
      m_full  = (mq.size() == DEPTH);
      m_empty = (mq.size() == 0);
      if (inValid && m_full) ovf_m = 1;
      if (outReady && !m_empty) void'(mq.pop_front());
      if (inValid && !m_full) begin
        mq.push_back({isAnd, resultIn});
        if (isAnd) and_m++;
        else or_m++;
      end
    end
  end

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("inReady", int'(inReady), int'(mq.size() < DEPTH));
      chk("outValid", int'(outValid), int'(mq.size() > 0));
      chk("level", int'(level), mq.size());
      if (mq.size() > 0) begin
        chk("outIsAnd", int'(outIsAnd), int'(mq[0][WIDTH]));
        chk("outData", int'(outData), int'(mq[0][WIDTH-1:0]));
        chk("outData_c2", int'(outData2), int'(mq[0][WIDTH-1:0]));
      end
      chk("andCount", int'(andCount), sat(and_m, 255));
      chk("orCount", int'(orCount), sat(or_m, 255));
      chk("andCount_c2", int'(andCount2), sat(and_m, 3));
      chk("orCount_c2", int'(orCount2), sat(or_m, 3));
      chk("level_c2", int'(level2), mq.size());
      chk("overflow", int'(overflow), int'(ovf_m));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    inValid = 0; outReady = 0;
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic drive(input logic v, input logic a, input logic [WIDTH-1:0] d, input logic r);
    inValid = v; isAnd = a; resultIn = d; outReady = r;
    tick();
  endtask

  initial begin
    logic [WIDTH:0] exp_seq [4];
    exp_seq[0] = 5'b1_0001; exp_seq[1] = 5'b0_0111;
    exp_seq[2] = 5'b1_0001; exp_seq[3] = 5'b0_0111;

    #2;
    do_reset();
    chk("rst_outValid", int'(outValid), 0);
    chk("rst_inReady", int'(inReady), 1);
    chk("rst_level", int'(level), 0);

    // Single push
    drive(1, 1, 4'b0001, 0);
    inValid = 0;
    chk("s1_outValid", int'(outValid), 1);
    chk("s1_outIsAnd", int'(outIsAnd), 1);
    chk("s1_outData", int'(outData), 1);
    chk("s1_level", int'(level), 1);
    chk("s1_andCount", int'(andCount), 1);

    // Fill, then push into full
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, exp_seq[i][WIDTH], exp_seq[i][WIDTH-1:0], 0);
    chk("s2_inReady", int'(inReady), 0);
    chk("s2_level", int'(level), 4);
    drive(1, 1, 4'b1111, 0);
    chk("s2_overflow", int'(overflow), 1);
    chk("s2_andCount", int'(andCount), 2);
    chk("s2_orCount", int'(orCount), 2);
    inValid = 0; outReady = 1;
    for (int i = 0; i < 4; i++) begin
      chk("s2_pop_data", int'({outIsAnd, outData}), int'(exp_seq[i]));
      tick();
    end
    chk("s2_drained", int'(outValid), 0);

    // Push and pop together from full, across the pointer wrap
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 0, 4'(i + 1), 0);
    drive(1, 1, 4'hA, 1);
    chk("s3_level_a", int'(level), 3);
    chk("s3_head_a", int'(outData), 2);
    drive(1, 1, 4'hB, 1);
    chk("s3_level_b", int'(level), 3);
    chk("s3_head_b", int'(outData), 3);

    // Streaming with alternating isAnd
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1, logic'(i % 2 == 0), 4'(i), 1);
      chk("s4_outValid", int'(outValid), 1);
      chk("s4_level", int'(level), 1);
      chk("s4_data", int'(outData), i % 16);
    end
    chk("s4_andCount", int'(andCount), 10);
    chk("s4_orCount", int'(orCount), 10);
    inValid = 0;
    tick();

    // Saturation on the narrow-counter instance
    do_reset();
    for (int i = 0; i < 5; i++) drive(1, 1, 4'h5, 1);
    chk("s5_andCount_c2", int'(andCount2), 3);
    chk("s5_orCount_c2", int'(orCount2), 0);
    chk("s5_andCount", int'(andCount), 5);

    // Asynchronous reset between edges
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 1, 4'h3, 0);
    drive(1, 0, 4'h6, 0);
    drive(0, 0, 4'h0, 1);
    outReady = 0;
    chk("s6_level", int'(level), 3);
    chk("s6_overflow", int'(overflow), 1);
    #1 rst = 1;
    #1;
    chk("s6_ar_outValid", int'(outValid), 0);
    chk("s6_ar_level", int'(level), 0);
    chk("s6_ar_inReady", int'(inReady), 1);
    chk("s6_ar_andCount", int'(andCount), 0);
    chk("s6_ar_overflow", int'(overflow), 0);
    tick();
    rst = 0;
    drive(1, 1, 4'b0001, 0);
    inValid = 0;
    chk("s6_re_data", int'({outIsAnd, outData}), 5'b1_0001);
    chk("s6_re_andCount", int'(andCount), 1);
    chk("s6_re_level", int'(level), 1);

    // Randomized traffic with occasional resets
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        drive(logic'($urandom_range(0, 9) < 7), logic'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), logic'($urandom_range(0, 9) < 6));
      end
    end
    inValid = 0; outReady = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
